// File: rtl/mips32_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mips32_prog_loader
//  Description : Boot loader for the pipe_MIPS32 core. Accepts a framed byte
//                stream (HDR, N, 4*N big-endian data bytes, XOR checksum) on
//                a valid/ready interface. It writes each assembled 32-bit
//                instruction word into the core's unified memory starting at
//                BASE_ADDR, and it holds the core halted while loading. On a
//                good checksum it releases the core with a one-cycle start
//                pulse.
//  Ports       : clk1        - single clock, rising edge
//                rst         - synchronous active-high reset
//                in_valid    - byte stream valid
//                in_data     - byte stream data
//                in_ready    - loader accepts byte (transfer = valid & ready)
//                mem_we      - memory write strobe, one cycle per word
//                mem_addr    - memory word address
//                mem_wdata   - instruction word
//                core_halt   - holds core halted while 1
//                core_start  - one-cycle release pulse (PC := 0)
//                done        - load completed, core running
//                err         - sticky: bad checksum or oversize frame
//  Revision    : 1.0 - initial release
// ============================================================================
module mips32_prog_loader #(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter logic [7:0]  HDR       = 8'hA5
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_halt,
    output logic              core_start,
    output logic              done,
    output logic              err
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_len  = 3'd1;
    localparam logic [2:0] c_st_data = 3'd2;
    localparam logic [2:0] c_st_chk  = 3'd3;
    localparam logic [2:0] c_st_run  = 3'd4;

    // One past the last legal word address; a frame may end exactly here.
    localparam logic [32:0] c_limit = 33'd1 << ADDR_W;

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    logic [2:0]        r_state,      w_state_nx;
    logic [7:0]        r_count,      w_count_nx;
    logic [7:0]        r_idx,        w_idx_nx;
    logic [1:0]        r_bpos,       w_bpos_nx;
    logic [31:0]       r_asm,        w_asm_nx;
    logic [7:0]        r_acc,        w_acc_nx;
    logic              r_in_ready,   w_in_ready_nx;
    logic              r_mem_we,     w_mem_we_nx;
    logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nx;
    logic [31:0]       r_mem_wdata,  w_mem_wdata_nx;
    logic              r_core_halt,  w_core_halt_nx;
    logic              r_core_start, w_core_start_nx;
    logic              r_done,       w_done_nx;
    logic              r_err,        w_err_nx;

    logic              w_xfer;
    logic [31:0]       w_asm_shift;
    logic [32:0]       w_end;

    assign w_xfer      = in_valid & r_in_ready;
    assign w_asm_shift = {r_asm[23:0], in_data};
    assign w_end       = 33'(BASE_ADDR) + {25'd0, in_data};

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nx      = r_state;
        w_count_nx      = r_count;
        w_idx_nx        = r_idx;
        w_bpos_nx       = r_bpos;
        w_asm_nx        = r_asm;
        w_acc_nx        = r_acc;
        w_in_ready_nx   = 1'b1;
        w_mem_we_nx     = 1'b0;
        w_mem_addr_nx   = r_mem_addr;
        w_mem_wdata_nx  = r_mem_wdata;
        w_core_halt_nx  = r_core_halt;
        w_core_start_nx = 1'b0;
        w_done_nx       = r_done;
        w_err_nx        = r_err;

        if (w_xfer) begin
            case (r_state)
                // IDLE and RUN share header detection; anything else drops.
                c_st_idle, c_st_run: begin
                    if (in_data == HDR) begin
                        w_core_halt_nx = 1'b1;
                        w_done_nx      = 1'b0;
                        w_err_nx       = 1'b0;
                        w_state_nx     = c_st_len;
                    end
                end

                c_st_len: begin
                    w_count_nx = in_data;
                    w_idx_nx   = 8'd0;
                    w_bpos_nx  = 2'd0;
                    w_acc_nx   = 8'd0;
                    if (w_end > c_limit) begin
                        w_err_nx   = 1'b1;
                        w_state_nx = c_st_idle;
                    end else if (in_data == 8'd0) begin
                        w_state_nx = c_st_chk;
                    end else begin
                        w_state_nx = c_st_data;
                    end
                end

                c_st_data: begin
                    w_asm_nx  = w_asm_shift;
                    w_acc_nx  = r_acc ^ in_data;
                    w_bpos_nx = r_bpos + 2'd1;
                    if (r_bpos == 2'd3) begin
                        // Word complete: write next cycle and block input for
                        // that cycle, giving 4 bytes per 5 cycles.
                        w_mem_we_nx    = 1'b1;
                        w_mem_addr_nx  = ADDR_W'(BASE_ADDR) + ADDR_W'(r_idx);
                        w_mem_wdata_nx = w_asm_shift;
                        w_in_ready_nx  = 1'b0;
                        w_idx_nx       = r_idx + 8'd1;
                        if ((r_idx + 8'd1) == r_count) begin
                            w_state_nx = c_st_chk;
                        end
                    end
                end

                c_st_chk: begin
                    if (in_data == r_acc) begin
                        w_core_halt_nx  = 1'b0;
                        w_core_start_nx = 1'b1;
                        w_done_nx       = 1'b1;
                        w_state_nx      = c_st_run;
                    end else begin
                        w_err_nx   = 1'b1;
                        w_state_nx = c_st_idle;
                    end
                end

                default: begin
                    w_state_nx = c_st_idle;
                end
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_count      <= 8'd0;
            r_idx        <= 8'd0;
            r_bpos       <= 2'd0;
            r_asm        <= 32'd0;
            r_acc        <= 8'd0;
            r_in_ready   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'd0;
            r_core_halt  <= 1'b1;
            r_core_start <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_count      <= w_count_nx;
            r_idx        <= w_idx_nx;
            r_bpos       <= w_bpos_nx;
            r_asm        <= w_asm_nx;
            r_acc        <= w_acc_nx;
            r_in_ready   <= w_in_ready_nx;
            r_mem_we     <= w_mem_we_nx;
            r_mem_addr   <= w_mem_addr_nx;
            r_mem_wdata  <= w_mem_wdata_nx;
            r_core_halt  <= w_core_halt_nx;
            r_core_start <= w_core_start_nx;
            r_done       <= w_done_nx;
            r_err        <= w_err_nx;
        end
    end

    assign in_ready   = r_in_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign core_halt  = r_core_halt;
    assign core_start = r_core_start;
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire
